// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Bit order: {WB, MEM, EX, ID, IF, PC}
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000E;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_IF   = 3'd1,
    CAUSE_ID   = 3'd2,
    CAUSE_EX   = 3'd3,
    CAUSE_MEM  = 3'd4
  } cause_e;

  function automatic logic [31:0] redirect_pc(input logic [31:0] exc,
                                              input logic [31:0] epc,
                                              input logic [31:0] eret_code,
                                              input logic [31:0] exc_vec);
    return (exc == eret_code) ? epc : exc_vec;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall request / flush control bundle between pipeline stages and the controller.
interface pipe_stall_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        flush_pending;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, flush_pending
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, flush_pending
  );
endinterface

// File: rtl/pipe_stall_ctrl_prio_enc.sv
// Fixed-priority merge of stage stall requests: deepest requesting stage wins.
module stall_prio_enc
  import pipe_stall_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] stall_o,
  output cause_e     cause_o
);
  always_comb begin
    stall_o = STALL_NONE;
    cause_o = CAUSE_NONE;
    if (req_mem_i) begin
      stall_o = STALL_MEM;
      cause_o = CAUSE_MEM;
    end else if (req_ex_i) begin
      stall_o = STALL_EX;
      cause_o = CAUSE_EX;
    end else if (req_id_i) begin
      stall_o = STALL_ID;
      cause_o = CAUSE_ID;
    end else if (req_if_i) begin
      stall_o = STALL_IF;
      cause_o = CAUSE_IF;
    end
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall merge plus exception/ERET flush sequencer; flushes wait out MEM bus stalls.
// Optional per-cause stall counters are built when CTRL_PERF_EN is defined.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_id,
  output logic [CNT_W-1:0]  stall_cnt_ex,
  output logic [CNT_W-1:0]  stall_cnt_mem
`endif
);
  state_e      state_q, state_d;
  logic [31:0] exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  enc_stall;
  cause_e      enc_cause, cause_eff;

  stall_prio_enc u_prio (
    .req_if_i  (bus.stallreq_if),
    .req_id_i  (bus.stallreq_id),
    .req_ex_i  (bus.stallreq_ex),
    .req_mem_i (bus.stallreq_mem),
    .stall_o   (enc_stall),
    .cause_o   (enc_cause)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      exc_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    exc_d             = exc_q;
    epc_d             = epc_q;
    bus.stall         = enc_stall;
    bus.flush         = 1'b0;
    bus.new_pc        = '0;
    bus.flush_pending = 1'b0;
    cause_eff         = enc_cause;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.excepttype_i != '0) begin
          if (!bus.stallreq_mem) begin
            bus.flush  = 1'b1;
            bus.stall  = STALL_NONE;
            bus.new_pc = redirect_pc(bus.excepttype_i, bus.cp0_epc_i, ERET_CODE, EXC_VECTOR);
            cause_eff  = CAUSE_NONE;
            state_d    = ST_FLUSH;
          end else begin
            exc_d   = bus.excepttype_i;
            epc_d   = bus.cp0_epc_i;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        // Hold everything behind MEM until the bus transfer drains.
        bus.flush_pending = 1'b1;
        bus.stall         = STALL_MEM;
        cause_eff         = CAUSE_MEM;
        if (!bus.stallreq_mem) begin
          bus.flush  = 1'b1;
          bus.stall  = STALL_NONE;
          bus.new_pc = redirect_pc(exc_q, epc_q, ERET_CODE, EXC_VECTOR);
          cause_eff  = CAUSE_NONE;
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Guaranteed clean cycle for the first redirected instruction.
        bus.stall = STALL_NONE;
        cause_eff = CAUSE_NONE;
        state_d   = ST_IDLE;
      end
      default: begin
        bus.stall = STALL_NONE;
        cause_eff = CAUSE_NONE;
        state_d   = ST_IDLE;
      end
    endcase
    if (rst) begin
      bus.stall         = STALL_NONE;
      bus.flush         = 1'b0;
      bus.new_pc        = '0;
      bus.flush_pending = 1'b0;
    end
  end

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_id_q, cnt_ex_q, cnt_mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_id_q  <= '0;
      cnt_ex_q  <= '0;
      cnt_mem_q <= '0;
    end else begin
      if (cause_eff == CAUSE_ID)  cnt_id_q  <= cnt_id_q + 1'b1;
      if (cause_eff == CAUSE_EX)  cnt_ex_q  <= cnt_ex_q + 1'b1;
      if (cause_eff == CAUSE_MEM) cnt_mem_q <= cnt_mem_q + 1'b1;
    end
  end

  assign stall_cnt_id  = cnt_id_q;
  assign stall_cnt_ex  = cnt_ex_q;
  assign stall_cnt_mem = cnt_mem_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed table-driven bench for pipe_stall_ctrl; perf counter checks when CTRL_PERF_EN is defined.
module tb_pipe_stall_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus();

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_id, cnt_ex, cnt_mem;
`endif

  pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CTRL_PERF_EN
    ,
    .stall_cnt_id  (cnt_id),
    .stall_cnt_ex  (cnt_ex),
    .stall_cnt_mem (cnt_mem)
`endif
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;    // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        pend;
    string       name;
  } vec_t;

  vec_t vt[$];
  int passed = 0;
  int total  = 0;

  task automatic add(input logic r, input logic [3:0] q, input logic [31:0] e, input logic [31:0] p,
                     input logic [5:0] s, input logic f, input logic [31:0] pc, input logic pd,
                     input string n);
    vec_t v;
    v.rst = r; v.req = q; v.exc = e; v.epc = p;
    v.stall = s; v.flush = f; v.pc = pc; v.pend = pd; v.name = n;
    vt.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] e, input logic [31:0] p);
    rst              = r;
    bus.stallreq_if  = q[0];
    bus.stallreq_id  = q[1];
    bus.stallreq_ex  = q[2];
    bus.stallreq_mem = q[3];
    bus.excepttype_i = e;
    bus.cp0_epc_i    = p;
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  initial begin
    drive(1'b1, 4'b0000, 32'h0, 32'h0);

    //   rst  {m,e,i,f}  exc          epc          stall      fl  pc           pd
    add(1'b1, 4'b1111, 32'h1,       32'h0,       6'b000000, 0, 32'h0,       0, "reset_outputs");
    add(1'b0, 4'b0000, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0, "idle_none");
    add(1'b0, 4'b0001, 32'h0,       32'h0,       6'b000011, 0, 32'h0,       0, "if_only");
    add(1'b0, 4'b0010, 32'h0,       32'h0,       6'b000111, 0, 32'h0,       0, "id_only");
    add(1'b0, 4'b0110, 32'h0,       32'h0,       6'b001111, 0, 32'h0,       0, "id_ex_prio");
    add(1'b0, 4'b1111, 32'h0,       32'h0,       6'b011111, 0, 32'h0,       0, "all_prio_mem");
    add(1'b0, 4'b0000, 32'h1,       32'h0,       6'b000000, 1, 32'h20,      0, "exc_idle_flush");
    add(1'b0, 4'b0010, 32'h1,       32'h0,       6'b000000, 0, 32'h0,       0, "flush_clean");
    add(1'b0, 4'b0010, 32'h0,       32'h0,       6'b000111, 0, 32'h0,       0, "back_idle");
    add(1'b0, 4'b1000, 32'hE,       32'h1000,    6'b011111, 0, 32'h0,       0, "eret_capture");
    add(1'b0, 4'b1010, 32'h8,       32'h2000,    6'b011111, 0, 32'h0,       1, "pend_1");
    add(1'b0, 4'b1000, 32'h8,       32'h2000,    6'b011111, 0, 32'h0,       1, "pend_2");
    add(1'b0, 4'b0000, 32'h0,       32'h0,       6'b000000, 1, 32'h1000,    1, "pend_release_eret");
    add(1'b0, 4'b1000, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0, "flush_after_pend");
    add(1'b0, 4'b0000, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0, "idle_again");
    add(1'b0, 4'b1000, 32'h5,       32'h0,       6'b011111, 0, 32'h0,       0, "exc5_capture");
    add(1'b0, 4'b0000, 32'h0,       32'h0,       6'b000000, 1, 32'h20,      1, "exc5_release");
    add(1'b0, 4'b0100, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0, "exc5_flush_cyc");
    add(1'b0, 4'b0100, 32'h0,       32'h0,       6'b001111, 0, 32'h0,       0, "ex_only");
    add(1'b0, 4'b1000, 32'h1,       32'h0,       6'b011111, 0, 32'h0,       0, "rstpend_capture");
    add(1'b0, 4'b1000, 32'h1,       32'h0,       6'b011111, 0, 32'h0,       1, "rstpend_pend");
    add(1'b1, 4'b0000, 32'h1,       32'h0,       6'b000000, 0, 32'h0,       0, "rst_in_pend");
    add(1'b0, 4'b0000, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0, "post_rst_noflush");
    add(1'b0, 4'b0010, 32'h0,       32'h0,       6'b000111, 0, 32'h0,       0, "post_rst_idle");
    add(1'b0, 4'b0000, 32'hE,       32'h44,      6'b000000, 1, 32'h44,      0, "eret_idle");
    add(1'b0, 4'b0001, 32'hE,       32'h44,      6'b000000, 0, 32'h0,       0, "eret_flush_cyc");

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].req, vt[i].exc, vt[i].epc);
      #2;
      check({vt[i].name, ".stall"}, {26'h0, bus.stall}, {26'h0, vt[i].stall});
      check({vt[i].name, ".flush"}, {31'h0, bus.flush}, {31'h0, vt[i].flush});
      check({vt[i].name, ".new_pc"}, bus.new_pc, vt[i].pc);
      check({vt[i].name, ".pend"}, {31'h0, bus.flush_pending}, {31'h0, vt[i].pend});
    end

    // Long PEND: flush must appear exactly at release, bounded by a cycle budget.
    begin
      int flushes = 0;
      int pend_cycles = 0;
      @(negedge clk); drive(1'b0, 4'b1000, 32'h3, 32'h0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk); drive(1'b0, 4'b1000, 32'hE, 32'h3000 + c);
        #2;
        if (bus.flush) flushes++;
        if (bus.flush_pending && bus.stall == 6'b011111) pend_cycles++;
      end
      check("long_pend.cycles", pend_cycles, 6);
      check("long_pend.no_early_flush", flushes, 0);
      @(negedge clk); drive(1'b0, 4'b0000, 32'h0, 32'h0);
      #2;
      check("long_pend.release_pc", bus.new_pc, 32'h20);
      check("long_pend.release_flush", {31'h0, bus.flush}, 32'h1);
    end

`ifdef CTRL_PERF_EN
    @(negedge clk); drive(1'b1, 4'b0000, 32'h0, 32'h0);
    @(negedge clk); drive(1'b0, 4'b0110, 32'h0, 32'h0);
    @(negedge clk); drive(1'b0, 4'b0000, 32'h0, 32'h0);
    #2;
    check("perf.ex_after_id_ex", {28'h0, cnt_ex}, 32'h1);
    check("perf.id_after_id_ex", {28'h0, cnt_id}, 32'h0);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk); drive(1'b0, 4'b1000, 32'h0, 32'h0);
    end
    @(negedge clk); drive(1'b0, 4'b0000, 32'h0, 32'h0);
    #2;
    check("perf.mem_wrap", {28'h0, cnt_mem}, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
